turf_trig_source_arbiter: RTL and testbench
===========================================

// Module: turf_trig_source_arbiter
// PURPOSE
//  Parametrised trigger-source combiner for the TURF trigger path.
//  - Replaces the ad-hoc soft/ext OR in the top level.
//  - Takes NUM_SRC raw trigger sources (soft, ext, PPS1, PPS2, ...), synchronises them, detects rising edges and applies per-source enables.
//  - Issues one accepted trigger pulse with a source bitmap, enforces a programmable holdoff and honours downstream busy.
//  - Keeps per-source accepted counts and a lost-trigger count for the scaler readout.
// PARAMETERS
//  NUM_SRC    4        number of trigger sources (1..16)
//  SYNC_MASK  4'b0010  bit k=1: source k is asynchronous, gets a 2-FF synchroniser
//  HOLDOFF_W  16       width of holdoff count
//  CNT_W      16       width of per-source and lost counters
// PORTS
//  clk_i       in   1                 trigger-domain clock (CLK33)
//  rst_n_i     in   1                 asynchronous active-low reset
//  src_i       in   NUM_SRC           raw trigger source levels
//  en_i        in   NUM_SRC           per-source enable, sampled on the edge cycle
//  holdoff_i   in   HOLDOFF_W         dead cycles after each accepted trigger
//  busy_i      in   1                 downstream cannot accept a trigger this cycle
//  trig_o      out  1                 one-cycle accepted-trigger pulse
//  trig_src_o  out  NUM_SRC           sources that caused the last trigger; held until the next trigger
//  cnt_sel_i   in   clog2(NUM_SRC+1)  counter select: 0..NUM_SRC-1 per source, NUM_SRC = lost
//  cnt_o       out  CNT_W             selected counter, registered
//  cnt_clr_i   in   1                 synchronous clear of all counters
// BEHAVIOUR
//  Reset values
//  - trig_o=0, trig_src_o=0, cnt_o=0, all counters 0, holdoff counter 0, state IDLE.
//  - Synchroniser and prev-level flops reset to 1. A source already high at reset release gives no trigger.
//  Front end
//  - s[k] = src_i[k] after 2 flops if SYNC_MASK[k], otherwise src_i[k] directly.
//  - prev[k] <= s[k] every cycle.
//  - edge[k] = s[k] & ~prev[k].
//  - hit = edge & en_i. Edges on disabled sources are ignored and are not counted as lost.
//  Latency (src_i rise to trig_o high, in IDLE, not busy)
//  - Unsynchronised source: 1 clk.
//  - Synchronised source: 3 clk.
//  FSM: IDLE, HOLDOFF
//  - IDLE, |hit & !busy_i:
//    - trig_o<=1, trig_src_o<=hit.
//    - Per-source cnt[k]++ for every hit[k].
//    - hcnt<=holdoff_i.
//    - Go to HOLDOFF if holdoff_i!=0, else stay in IDLE.
//  - IDLE, |hit & busy_i: no trigger, lost++ (once per cycle, whatever the popcount).
//  - HOLDOFF: hcnt-- each cycle. |hit gives lost++. When hcnt==1, go to IDLE next cycle.
//    - holdoff_i=N means exactly N cycles after the trigger cycle reject hits.
//    - Earliest next trig_o is N+1 cycles after the previous one.
//  - holdoff_i changes during HOLDOFF take effect only at the next trigger.
//  Simultaneous hits
//  - Hits on several sources in one cycle give one trig_o, with all bits set in trig_src_o.
//  Counters
//  - All counters saturate at all-ones and never wrap.
//  - cnt_clr_i has priority over increment in the same cycle.
//  - cnt_o <= mux(cnt_sel_i), 1-cycle latency.
//  - cnt_sel_i > NUM_SRC returns 0.
//  Reset
//  - Asserting rst_n_i mid-HOLDOFF aborts it immediately: state IDLE, counts and outputs 0.
//  - A source held high through reset release must first go low, then rise, to trigger.
// TESTING
//  1. holdoff=0, src 0 (unsynced) pulses rise at cycles 10 and 12.
//     -> trig_o at 11 and 13, trig_src_o=4'b0001, cnt[0]=2.
//  2. src 1 (synced) rises at cycle 20.
//     -> trig_o at cycle 23, trig_src_o=4'b0010.
//  3. holdoff=5, src 0 rises at cycle 0, src 2 rises at cycles 3 and 6.
//     -> trig at 1 and 7, lost=1, trig_src_o=4'b0100 after the second trigger.
//  4. Srcs 0 and 2 rise together with busy_i=1.
//     -> no trig_o, lost=1.
//     Same stimulus with busy_i=0 -> one trig_o, trig_src_o=4'b0101.
//  5. en_i=4'b1110, src 0 rises -> no trig_o, lost unchanged.
//     Preload cnt[3] to 16'hFFFF, trigger src 3 -> cnt[3] stays 16'hFFFF.
//  6. Assert rst_n_i at hcnt=3 with src 0 held high; release.
//     -> all outputs 0, no trig_o until src 0 falls and rises again.
//     Also: cnt_clr_i coincident with a hit -> counter reads 0.

Source files
------------

// File: rtl/turf_trig_source_arbiter.sv
// TURF trigger-source combiner.
// Synchronises the raw trigger sources and picks out their rising edges.
// Issues one accepted trigger with a source bitmap, then applies a holdoff.
// Keeps saturating per-source and lost-trigger counters for scaler readout.
//
// state   | meaning
// IDLE    | ready to accept a trigger
// HOLDOFF | dead time after an accepted trigger; any hit is counted as lost
module turf_trig_source_arbiter #(
  parameter int          NUM_SRC   = 4,
  parameter logic [15:0] SYNC_MASK = 16'h0002,
  parameter int          HOLDOFF_W = 16,
  parameter int          CNT_W     = 16,
  localparam int         SEL_W     = $clog2(NUM_SRC + 1)
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic [NUM_SRC-1:0]   src_i,
  input  logic [NUM_SRC-1:0]   en_i,
  input  logic [HOLDOFF_W-1:0] holdoff_i,
  input  logic                 busy_i,
  output logic                 trig_o,
  output logic [NUM_SRC-1:0]   trig_src_o,
  input  logic [SEL_W-1:0]     cnt_sel_i,
  output logic [CNT_W-1:0]     cnt_o,
  input  logic                 cnt_clr_i
);

  typedef enum logic {IDLE, HOLDOFF} state_t;

  state_t               state_q;
  logic [HOLDOFF_W-1:0] hcnt_q;
  logic                 trig_q;
  logic [NUM_SRC-1:0]   trig_src_q;
  logic [NUM_SRC-1:0]   sync1_q, sync2_q, prev_q;
  logic [NUM_SRC-1:0]   src_s, rise, hit;
  logic [NUM_SRC-1:0]   src_inc;
  logic                 lost_inc;
  logic [NUM_SRC:0]     inc;
  logic [CNT_W-1:0]     cnt_q [NUM_SRC+1];
  logic [CNT_W-1:0]     cnt_sel_d;
  logic [CNT_W-1:0]     cnt_o_q;

  // Synchroniser and previous-level flops reset high so a source already
  // high at reset release never looks like a fresh edge.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sync1_q <= '1;
      sync2_q <= '1;
      prev_q  <= '1;
    end else begin
      sync1_q <= src_i;
      sync2_q <= sync1_q;
      prev_q  <= src_s;
    end
  end

  // Per-source level selection, edge detect and enable gating.
  always_comb begin
    src_s = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      src_s[k] = SYNC_MASK[k] ? sync2_q[k] : src_i[k];
    end
    rise = src_s & ~prev_q;
    hit  = rise & en_i;
  end

  // Accept/holdoff state machine with registered trigger outputs.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= IDLE;
      hcnt_q     <= '0;
      trig_q     <= 1'b0;
      trig_src_q <= '0;
    end else begin
      trig_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if ((|hit) && !busy_i) begin
            trig_q     <= 1'b1;
            trig_src_q <= hit;
            hcnt_q     <= holdoff_i;
            if (holdoff_i != '0) state_q <= HOLDOFF;
          end
        end
        HOLDOFF: begin
          hcnt_q <= hcnt_q - 1'b1;
          if (hcnt_q == HOLDOFF_W'(1)) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Increment requests: accepted sources, plus one lost count per rejected cycle.
  always_comb begin
    src_inc  = '0;
    lost_inc = 1'b0;
    if (|hit) begin
      if (state_q == IDLE && !busy_i) src_inc  = hit;
      else                            lost_inc = 1'b1;
    end
    inc = {lost_inc, src_inc};
  end

  // Saturating counters; clear wins over a same-cycle increment.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int k = 0; k <= NUM_SRC; k++) cnt_q[k] <= '0;
    end else begin
      for (int k = 0; k <= NUM_SRC; k++) begin
        if (cnt_clr_i)                     cnt_q[k] <= '0;
        else if (inc[k] && cnt_q[k] != '1) cnt_q[k] <= cnt_q[k] + 1'b1;
      end
    end
  end

  // Readout mux; out-of-range selects read as zero.
  always_comb begin
    cnt_sel_d = '0;
    for (int k = 0; k <= NUM_SRC; k++) begin
      if (cnt_sel_i == SEL_W'(k)) cnt_sel_d = cnt_q[k];
    end
  end

  // Registered counter readout.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) cnt_o_q <= '0;
    else          cnt_o_q <= cnt_sel_d;
  end

  assign trig_o     = trig_q;
  assign trig_src_o = trig_src_q;
  assign cnt_o      = cnt_o_q;

endmodule

// File: tb/tb_turf_trig_source_arbiter.sv
// Directed bench for turf_trig_source_arbiter.
// A second instance with 4-bit counters exercises counter saturation.
module tb_turf_trig_source_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  src, en;
  logic [15:0] holdoff;
  logic        busy, cnt_clr;
  logic [2:0]  cnt_sel;
  logic        trig, trig_s;
  logic [3:0]  trig_src, trig_src_s;
  logic [15:0] cnt;
  logic [3:0]  cnt_s;

  int errors = 0;
  int checks = 0;
  logic [31:0] rd;

  always #5 clk = ~clk;

  turf_trig_source_arbiter u_dut (
    .clk_i(clk), .rst_n_i(rst_n), .src_i(src), .en_i(en), .holdoff_i(holdoff),
    .busy_i(busy), .trig_o(trig), .trig_src_o(trig_src), .cnt_sel_i(cnt_sel),
    .cnt_o(cnt), .cnt_clr_i(cnt_clr)
  );

  turf_trig_source_arbiter #(.CNT_W(4)) u_sat (
    .clk_i(clk), .rst_n_i(rst_n), .src_i(src), .en_i(en), .holdoff_i(holdoff),
    .busy_i(busy), .trig_o(trig_s), .trig_src_o(trig_src_s), .cnt_sel_i(cnt_sel),
    .cnt_o(cnt_s), .cnt_clr_i(cnt_clr)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic read_cnt(input logic [2:0] sel, output logic [31:0] val);
    cnt_sel = sel;
    tick();
    val = {16'h0, cnt};
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; src = '0; en = 4'hF; holdoff = '0; busy = 1'b0;
    cnt_sel = '0; cnt_clr = 1'b0;
    tick(3);
    chk("rst_trig", trig, 0);
    chk("rst_trig_src", trig_src, 0);
    chk("rst_cnt", cnt, 0);
    rst_n = 1'b1;
    tick(5);
    chk("idle_no_trig", trig, 0);

    // unsynced src 0, two pulses two cycles apart, holdoff 0
    src[0] = 1'b1; tick();
    chk("t1_trig_a", trig, 1);
    chk("t1_src_a", trig_src, 4'b0001);
    src[0] = 1'b0; tick();
    chk("t1_gap", trig, 0);
    src[0] = 1'b1; tick();
    chk("t1_trig_b", trig, 1);
    src[0] = 1'b0; tick(3);
    chk("t1_src_held", trig_src, 4'b0001);
    read_cnt(3'd0, rd);
    chk("t1_cnt0", rd, 2);

    // synced src 1: three-cycle latency
    src[1] = 1'b1; tick();
    chk("t2_lat1", trig, 0);
    tick();
    chk("t2_lat2", trig, 0);
    tick();
    chk("t2_trig", trig, 1);
    chk("t2_src", trig_src, 4'b0010);
    src[1] = 1'b0; tick(4);

    // holdoff 5: src0 at 0, src2 at 3 (lost) and 6 (accepted)
    holdoff = 16'd5;
    src[0] = 1'b1; tick();
    chk("t3_trig_a", trig, 1);
    src[0] = 1'b0; tick(2);
    src[2] = 1'b1; tick();
    chk("t3_reject", trig, 0);
    src[2] = 1'b0; tick(2);
    src[2] = 1'b1; tick();
    chk("t3_trig_b", trig, 1);
    chk("t3_src", trig_src, 4'b0100);
    src[2] = 1'b0;
    holdoff = '0;
    tick(7);
    read_cnt(3'd4, rd);
    chk("t3_lost", rd, 1);

    // busy rejects a two-source hit as one lost
    busy = 1'b1; src = 4'b0101; tick();
    chk("t4_busy", trig, 0);
    busy = 1'b0; src = '0; tick();
    read_cnt(3'd4, rd);
    chk("t4_lost", rd, 2);
    src = 4'b0101; tick();
    chk("t4_trig", trig, 1);
    chk("t4_src", trig_src, 4'b0101);
    src = '0; tick();

    // disabled source: no trigger, no lost
    en = 4'b1110;
    src[0] = 1'b1; tick();
    chk("t5_dis", trig, 0);
    src[0] = 1'b0; tick();
    read_cnt(3'd4, rd);
    chk("t5_lost", rd, 2);
    en = 4'hF;

    // saturation on src 3 (20 triggers)
    for (int i = 0; i < 20; i++) begin
      src[3] = 1'b1; tick();
      src[3] = 1'b0; tick();
    end
    read_cnt(3'd3, rd);
    chk("t5_cnt3", rd, 20);
    chk("t5_sat", cnt_s, 4'hF);
    read_cnt(3'd5, rd);
    chk("sel_oob", rd, 0);

    // reset during holdoff with src 0 held high
    holdoff = 16'd5;
    src[0] = 1'b1; tick();
    chk("t6_trig", trig, 1);
    tick(2);
    rst_n = 1'b0; #1;
    chk("t6_rst_trig_src", trig_src, 0);
    chk("t6_rst_cnt", cnt, 0);
    tick(2);
    rst_n = 1'b1;
    holdoff = '0;
    tick();
    chk("t6_held_a", trig, 0);
    tick();
    chk("t6_held_b", trig, 0);
    read_cnt(3'd0, rd);
    chk("t6_cnt0_rst", rd, 0);
    src[0] = 1'b0; tick();
    src[0] = 1'b1; tick();
    chk("t6_retrig", trig, 1);
    chk("t6_src", trig_src, 4'b0001);
    src[0] = 1'b0; tick();
    read_cnt(3'd0, rd);
    chk("t6_cnt0", rd, 1);

    // clear coincident with a hit wins
    src[0] = 1'b1; cnt_clr = 1'b1; tick();
    chk("clr_trig", trig, 1);
    src[0] = 1'b0; cnt_clr = 1'b0; tick();
    read_cnt(3'd0, rd);
    chk("clr_cnt0", rd, 0);
    src[0] = 1'b1; tick();
    src[0] = 1'b0; tick();
    read_cnt(3'd0, rd);
    chk("clr_after", rd, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
